operand_loader: RTL and testbench

//  Parametrised RSA operand loader; successor to the fixed four-register loader. Owns the DMA receive

---
 rtl/operand_loader_pkg.sv | 22 ++
 rtl/operand_loader_if.sv | 26 ++
 rtl/operand_loader_bank.sv | 54 +++++
 rtl/operand_loader.sv | 193 +++++++++++++++++++
 tb/tb_operand_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types for the RSA operand loader: FSM states, error codes and default slot map.
// The optional watchdog is enabled with the LOADER_TIMEOUT_EN macro (see operand_loader).
package rsa_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DMA     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned SLOT_N   = 32'd0;
  localparam int unsigned SLOT_E   = 32'd1;
  localparam int unsigned SLOT_RN  = 32'd2;
  localparam int unsigned SLOT_R2N = 32'd3;

endpackage

// File: rtl/operand_loader_if.sv
// DMA receive handshake between the operand loader (master) and the DMA engine (slave).
interface operand_loader_if #(
  parameter int WIDTH = 1024
);
  logic [WIDTH-1:0] dma_rx_data;
  logic             dma_rx_start;
  logic             dma_done;
  logic             dma_idle;
  logic             dma_error;

  modport master (
    output dma_rx_start,
    input  dma_rx_data,
    input  dma_done,
    input  dma_idle,
    input  dma_error
  );

  modport slave (
    input  dma_rx_start,
    output dma_rx_data,
    output dma_done,
    output dma_idle,
    output dma_error
  );
endinterface

// File: rtl/operand_loader_bank.sv
// Operand register bank: one write port, flat read-out, per-slot valid bits
// (set on write, cleared by mask). Data words are not reset; valid bits qualify them.
module operand_bank #(
  parameter int WIDTH        = 1024,
  parameter int NUM_OPERANDS = 4,
  parameter int IDX_W        = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          we,
  input  logic [IDX_W-1:0]              idx,
  input  logic [WIDTH-1:0]              data,
  input  logic [NUM_OPERANDS-1:0]       clr_mask,
  output logic [NUM_OPERANDS*WIDTH-1:0] operands,
  output logic [NUM_OPERANDS-1:0]       valid
);

  logic [WIDTH-1:0]        mem_q [NUM_OPERANDS];
  logic [WIDTH-1:0]        mem_d [NUM_OPERANDS];
  logic [NUM_OPERANDS-1:0] valid_q, valid_d;

  // Next-state for data words and valid bits
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q & ~clr_mask;
    if (we) begin
      mem_d[idx]   = data;
      valid_d[idx] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
  end

  // Data storage, intentionally without reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Valid bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar i = 0; i < NUM_OPERANDS; i++) begin : g_flat
    assign operands[i*WIDTH +: WIDTH] = mem_q[i];
  end

  assign valid = valid_q;

endmodule

// File: rtl/operand_loader.sv
// RSA operand loader: fetches masked operand slots over DMA in ascending order.
// Define LOADER_TIMEOUT_EN to add a per-transfer watchdog of TIMEOUT_CYCLES WAIT cycles.
module operand_loader
  import rsa_loader_pkg::*;
#(
  parameter int WIDTH          = 1024,
  parameter int NUM_OPERANDS   = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [NUM_OPERANDS-1:0]       cmd_mask,
  output logic [NUM_OPERANDS*WIDTH-1:0] operands,
  output logic [NUM_OPERANDS-1:0]       operand_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [IDX_W-1:0]              err_index,
  operand_loader_if.master              dma
);

  loader_state_e           state_q, state_d;
  logic [NUM_OPERANDS-1:0] pending_q, pending_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [IDX_W-1:0]        err_index_q, err_index_d;
  logic                    start_q, start_d;
  logic [IDX_W-1:0]        cur_s;
  logic                    accept_s;
  logic                    we_s;
  logic [NUM_OPERANDS-1:0] clr_mask_s;

`ifdef LOADER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  assign accept_s = cmd_valid & cmd_ready_q;

  // Lowest set pending bit wins
  always_comb begin
    cur_s = '0;
    for (int i = NUM_OPERANDS - 1; i >= 0; i--) begin
      cur_s = pending_q[i] ? IDX_W'(i) : cur_s;
    end
  end

  // FSM next-state, bank control and registered-output next values
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    start_d     = 1'b0;
    we_s        = 1'b0;
    clr_mask_s  = '0;
`ifdef LOADER_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (accept_s) begin
          pending_d  = cmd_mask;
          clr_mask_s = cmd_mask;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = ISSUE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ISSUE: begin
        if (pending_q == '0) begin
          state_d = DONE;
        end else if (dma.dma_idle) begin
          start_d = 1'b1;
          state_d = WAIT;
`ifdef LOADER_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        // Error takes priority over a simultaneous completion; nothing is latched
        if (dma.dma_error) begin
          state_d     = ERROR;
          error_d     = 1'b1;
          err_code_d  = ERR_DMA;
          err_index_d = cur_s;
          pending_d   = '0;
        end else if (dma.dma_done) begin
          we_s             = 1'b1;
          pending_d[cur_s] = 1'b0;
          state_d          = ISSUE;
        end else begin
`ifdef LOADER_TIMEOUT_EN
          if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ERROR;
            error_d     = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            err_index_d = cur_s;
            pending_d   = '0;
          end else begin
            wdog_d = wdog_q + WDOG_W'(1);
          end
`else
          state_d = WAIT;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE) || (state_d == DONE) || (state_d == ERROR);
    busy_d      = (state_d == ISSUE) || (state_d == WAIT);
    done_d      = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
      start_q     <= start_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Per-transfer watchdog counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  operand_bank #(
    .WIDTH        (WIDTH),
    .NUM_OPERANDS (NUM_OPERANDS),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk      (clk),
    .resetn   (resetn),
    .we       (we_s),
    .idx      (cur_s),
    .data     (dma.dma_rx_data),
    .clr_mask (clr_mask_s),
    .operands (operands),
    .valid    (operand_valid)
  );

  assign cmd_ready        = cmd_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_code         = err_code_q;
  assign err_index        = err_index_q;
  assign dma.dma_rx_start = start_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed scoreboard bench for operand_loader: expected slot order is queued at command
// time and checked against the bank as each DMA transfer completes.
module tb_operand_loader;
  import rsa_loader_pkg::*;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [N-1:0]   cmd_mask = '0;
  logic           cmd_ready, busy, done, error;
  logic [N*W-1:0] operands;
  logic [N-1:0]   operand_valid;
  logic [1:0]     err_code;
  logic [IW-1:0]  err_index;

  operand_loader_if #(.WIDTH(W)) dma_if ();

  operand_loader #(
    .WIDTH(W), .NUM_OPERANDS(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mask      (cmd_mask),
    .operands      (operands),
    .operand_valid (operand_valid),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .err_index     (err_index),
    .dma           (dma_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int sb_q[$];
  logic [W-1:0] exp_data [N];
  logic [N-1:0] exp_valid = '0;

  always @(posedge clk) begin
    if (dma_if.dma_rx_start) start_cnt <= start_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [N-1:0] mask);
    check("cmd_ready_before", W'(cmd_ready), W'(1'b1));
    cmd_valid = 1'b1;
    cmd_mask  = mask;
    tick();
    cmd_valid = 1'b0;
    cmd_mask  = '0;
    for (int i = 0; i < N; i++) if (mask[i]) sb_q.push_back(i);
    exp_valid &= ~mask;
    check("busy_after_accept", W'(busy), W'(1'b1));
    check("error_cleared", W'(error), W'(1'b0));
    check("valid_cleared", W'(operand_valid), W'(exp_valid));
  endtask

  task automatic wait_start();
    for (int k = 0; k < 50 && !dma_if.dma_rx_start; k++) tick();
    check("start_seen", W'(dma_if.dma_rx_start), W'(1'b1));
  endtask

  // mode 0: dma_done, 1: dma_error, 2: both together
  task automatic serve(input int latency, input int mode);
    logic [W-1:0] data;
    int slot;
    wait_start();
    data = {$urandom, $urandom};
    tick();
    check("start_one_cycle", W'(dma_if.dma_rx_start), W'(1'b0));
    repeat (latency - 1) tick();
    dma_if.dma_rx_data = data;
    dma_if.dma_done    = (mode != 1);
    dma_if.dma_error   = (mode != 0);
    tick();
    dma_if.dma_done    = 1'b0;
    dma_if.dma_error   = 1'b0;
    dma_if.dma_rx_data = ~data;
    slot = (sb_q.size() > 0) ? sb_q.pop_front() : 0;
    if (mode == 0) begin
      exp_data[slot]  = data;
      exp_valid[slot] = 1'b1;
      check("slot_data", operands[slot*W +: W], exp_data[slot]);
    end else begin
      sb_q.delete();
      check("err_flag", W'(error), W'(1'b1));
      check("err_code", W'(err_code), W'(ERR_DMA));
      check("err_index", W'(err_index), W'(slot));
      check("err_busy", W'(busy), W'(1'b0));
      if (mode == 2) check("slot_not_written", operands[slot*W +: W], exp_data[slot]);
    end
    check("valid_bits", W'(operand_valid), W'(exp_valid));
  endtask

  task automatic finish_done();
    tick();
    check("done_pulse", W'(done), W'(1'b1));
    check("busy_in_done", W'(busy), W'(1'b0));
    tick();
    check("done_one_cycle", W'(done), W'(1'b0));
    check("ready_after_done", W'(cmd_ready), W'(1'b1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, W'(cmd_ready), W'(1'b1));
    check({tag, "_busy"}, W'(busy), W'(1'b0));
    check({tag, "_done"}, W'(done), W'(1'b0));
    check({tag, "_error"}, W'(error), W'(1'b0));
    check({tag, "_err_code"}, W'(err_code), W'(ERR_NONE));
    check({tag, "_err_index"}, W'(err_index), W'(0));
    check({tag, "_valid"}, W'(operand_valid), W'(0));
    check({tag, "_start"}, W'(dma_if.dma_rx_start), W'(1'b0));
  endtask

  initial begin
    int s0, d0;
    bit seen;
    dma_if.dma_rx_data = '0;
    dma_if.dma_done    = 1'b0;
    dma_if.dma_idle    = 1'b1;
    dma_if.dma_error   = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    resetn = 1'b1;
    tick();

    // 1: full load
    s0 = start_cnt; d0 = done_cnt;
    do_cmd(4'b1111);
    for (int i = 0; i < 4; i++) serve(5, 0);
    finish_done();
    check("t1_starts", W'(start_cnt - s0), W'(4));
    check("t1_dones", W'(done_cnt - d0), W'(1));
    check("t1_valid", W'(operand_valid), W'(4'b1111));

    // 2: sparse mask, slots 1 then 3
    s0 = start_cnt;
    do_cmd(4'b1010);
    check("t2_valid_partial", W'(operand_valid), W'(4'b0101));
    serve(3, 0);
    serve(4, 0);
    finish_done();
    check("t2_starts", W'(start_cnt - s0), W'(2));
    for (int i = 0; i < N; i++) check("t2_all_slots", operands[i*W +: W], exp_data[i]);

    // 3: DMA error on third transfer, then recover
    d0 = done_cnt;
    do_cmd(4'b1111);
    serve(5, 0);
    serve(5, 0);
    serve(5, 1);
    check("t3_valid_0011", W'(operand_valid), W'(4'b0011));
    s0 = start_cnt;
    repeat (3) tick();
    check("t3_no_more_starts", W'(start_cnt - s0), W'(0));
    check("t3_no_done", W'(done_cnt - d0), W'(0));
    check("t3_error_sticky", W'(error), W'(1'b1));
    do_cmd(4'b1100);
    check("t3_err_code_cleared", W'(err_code), W'(ERR_NONE));
    serve(2, 0);
    serve(2, 0);
    finish_done();
    check("t3_valid_1111", W'(operand_valid), W'(4'b1111));

    // 4: DMA busy holds off the start pulse
    dma_if.dma_idle = 1'b0;
    s0 = start_cnt;
    do_cmd(4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= dma_if.dma_rx_start;
    end
    check("t4_no_start_while_busy", W'(seen), W'(1'b0));
    dma_if.dma_idle = 1'b1;
    serve(5, 0);
    finish_done();
    check("t4_one_start", W'(start_cnt - s0), W'(1));

    // 5: simultaneous done+error, then empty mask
    do_cmd(4'b0100);
    serve(3, 2);
    s0 = start_cnt;
    do_cmd(4'b0000);
    check("t5_no_done_yet", W'(done), W'(1'b0));
    tick();
    check("t5_done_2_after", W'(done), W'(1'b1));
    tick();
    check("t5_done_cleared", W'(done), W'(1'b0));
    check("t5_no_start", W'(start_cnt - s0), W'(0));

    // reset during WAIT; a later completion must be ignored
    do_cmd(4'b1000);
    wait_start();
    tick();
    resetn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    sb_q.delete();
    exp_valid = '0;
    tick();
    resetn = 1'b1;
    tick();
    dma_if.dma_rx_data = 64'hDEAD_BEEF_0000_0001;
    dma_if.dma_done    = 1'b1;
    tick();
    dma_if.dma_done = 1'b0;
    tick();
    check_reset_vals("late_done_ignored");

`ifdef LOADER_TIMEOUT_EN
    // 6: watchdog with no DMA response
    do_cmd(4'b0001);
    wait_start();
    seen = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      seen |= error;
    end
    check("t6_no_early_timeout", W'(seen), W'(1'b0));
    tick();
    check("t6_timeout_error", W'(error), W'(1'b1));
    check("t6_timeout_code", W'(err_code), W'(ERR_TIMEOUT));
    check("t6_timeout_index", W'(err_index), W'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
